// File: rtl/cdp_fp_sum_pkg.sv
// Shared definitions for the CDP fp_sum_block datapath: payload width and
// the packed fp16 pair carried between the sum producer and its consumers.
package cdp_fp_sum_pkg;

    localparam int FP_SUM_PD_W = 32;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } fp_sum_pd_t;

endpackage : cdp_fp_sum_pkg

// File: rtl/fp_sum_pipe_reg.sv
// One valid/data storage entry: valid has an asynchronous clear, payload is
// unreset and only loads when its own enable is high.
module fp_sum_pipe_reg #(
    parameter int DW = 32
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          vld_en,
    input  logic          vld_d,
    input  logic          pd_en,
    input  logic [DW-1:0] pd_d,
    output logic          vld,
    output logic [DW-1:0] pd
);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            vld <= 1'b0;
        end else if (vld_en) begin
            vld <= vld_d;
        end
    end

    // Payload is don't-care while vld is low, so it carries no reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (pd_en) begin
            pd <= pd_d;
        end
    end

endmodule : fp_sum_pipe_reg

// File: rtl/fp_sum_block_pipe_skid.sv
// Ready-path register slice for fp_sum_block: skid entry plus output entry,
// every downstream and upstream handshake output driven from a flop.
// Optional simulation checkers: define FP_SUM_PIPE_SKID_ASSERT_EN.
module fp_sum_block_pipe_skid
    import cdp_fp_sum_pkg::*;
#(
    parameter int DW = FP_SUM_PD_W
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          pipe_in_vld,
    output logic          pipe_in_rdy,
    input  logic [DW-1:0] pipe_in_pd,
    output logic          pipe_out_vld,
    input  logic          pipe_out_rdy,
    output logic [DW-1:0] pipe_out_pd
);

    // Handshake: a beat moves on a rising edge where vld and rdy are both 1;
    // once vld is raised the sender holds vld and pd stable until that edge.

    logic          skid_vld;
    logic [DW-1:0] skid_pd;
    logic          out_vld;
    logic [DW-1:0] out_pd;

    logic          in_xfer;
    logic          out_ready_bc;
    logic          src_vld;
    logic [DW-1:0] src_pd;
    logic          skid_fill;
    logic          skid_drain;
    logic          skid_vld_en;

    assign in_xfer      = pipe_in_vld & pipe_in_rdy;
    assign out_ready_bc = pipe_out_rdy | ~out_vld;

    // Skid always holds the older beat, so it has priority over new input.
    assign src_vld = skid_vld | in_xfer;
    assign src_pd  = skid_vld ? skid_pd : pipe_in_pd;

    assign skid_drain  = skid_vld & out_ready_bc;
    assign skid_fill   = ~skid_vld & in_xfer & ~out_ready_bc;
    assign skid_vld_en = skid_drain | skid_fill;

    fp_sum_pipe_reg #(.DW(DW)) u_skid (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .vld_en         (skid_vld_en),
        .vld_d          (skid_fill),
        .pd_en          (skid_fill),
        .pd_d           (pipe_in_pd),
        .vld            (skid_vld),
        .pd             (skid_pd)
    );

    fp_sum_pipe_reg #(.DW(DW)) u_out (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .vld_en         (out_ready_bc),
        .vld_d          (src_vld),
        .pd_en          (out_ready_bc & src_vld),
        .pd_d           (src_pd),
        .vld            (out_vld),
        .pd             (out_pd)
    );

    // Dedicated flop tracking !skid_vld so upstream ready has no logic after it.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            pipe_in_rdy <= 1'b1;
        end else if (skid_vld_en) begin
            pipe_in_rdy <= ~skid_fill;
        end
    end

    assign pipe_out_vld = out_vld;
    assign pipe_out_pd  = out_pd;

`ifdef FP_SUM_PIPE_SKID_ASSERT_EN
    logic          chk_stall_q;
    logic [DW-1:0] chk_pd_q;

    always @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            chk_stall_q <= 1'b0;
            chk_pd_q    <= '0;
        end else begin
            if (chk_stall_q && (!out_vld || out_pd != chk_pd_q)) begin
                $error("fp_sum_block_pipe_skid: output changed while stalled");
            end
            if (skid_vld && !out_vld) begin
                $error("fp_sum_block_pipe_skid: skid_vld set with out_vld clear");
            end
            if ($isunknown(pipe_in_rdy)) begin
                $error("fp_sum_block_pipe_skid: pipe_in_rdy is X");
            end
            chk_stall_q <= out_vld & ~pipe_out_rdy;
            chk_pd_q    <= out_pd;
        end
    end
`endif

endmodule : fp_sum_block_pipe_skid

// File: tb/tb_fp_sum_block_pipe_skid.sv
// Directed bench for fp_sum_block_pipe_skid: stall/drain vector table,
// streaming, mid-operation reset and a random-backpressure scoreboard run.
module tb_fp_sum_block_pipe_skid;
    import cdp_fp_sum_pkg::*;

    localparam int DW = FP_SUM_PD_W;

    logic          nvdla_core_clk;
    logic          nvdla_core_rst;
    logic          pipe_in_vld;
    logic          pipe_in_rdy;
    logic [DW-1:0] pipe_in_pd;
    logic          pipe_out_vld;
    logic          pipe_out_rdy;
    logic [DW-1:0] pipe_out_pd;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          in_vld;
        logic [DW-1:0] in_pd;
        logic          out_rdy;
        logic          exp_in_rdy;
        logic          exp_out_vld;
        logic [DW-1:0] exp_out_pd;
    } vec_t;

    vec_t vecs[8];

    fp_sum_block_pipe_skid #(.DW(DW)) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .pipe_in_vld    (pipe_in_vld),
        .pipe_in_rdy    (pipe_in_rdy),
        .pipe_in_pd     (pipe_in_pd),
        .pipe_out_vld   (pipe_out_vld),
        .pipe_out_rdy   (pipe_out_rdy),
        .pipe_out_pd    (pipe_out_pd)
    );

    // Clock / reset
    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are all flops, so they are
    // sampled on that same falling edge, half a cycle away from the capture edge.
    task automatic drive(input logic vld, input logic [DW-1:0] pd, input logic rdy);
        @(negedge nvdla_core_clk);
        pipe_in_vld  = vld;
        pipe_in_pd   = pd;
        pipe_out_rdy = rdy;
    endtask

    function automatic logic [DW-1:0] mk(input logic [15:0] hi, input logic [15:0] lo);
        fp_sum_pd_t p;
        p.hi = hi;
        p.lo = lo;
        return p;
    endfunction

    task automatic run_random(input int n_beats);
        int sent    = 0;
        int got     = 0;
        int occ     = 0;
        int cycles  = 0;
        logic          vld;
        logic          rdy;
        logic          stalled_q = 1'b0;
        logic [DW-1:0] pd_q = '0;
        logic [DW-1:0] exp_pd;
        while ((got < n_beats) && (cycles < 20000)) begin
            vld = (sent < n_beats) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdy = 1'($urandom_range(0, 1));
            drive(vld, $urandom, rdy);
            cycles++;
            check("rand_in_rdy", DW'(pipe_in_rdy), DW'(occ < 2));
            check("rand_out_vld", DW'(pipe_out_vld), DW'(occ > 0));
            if (stalled_q) begin
                check("rand_stable_pd", pipe_out_pd, pd_q);
            end
            if (pipe_out_vld && rdy) begin
                exp_pd = (exp_q.size() > 0) ? exp_q.pop_front() : ~pipe_out_pd;
                check("rand_data", pipe_out_pd, exp_pd);
                got++;
                occ--;
            end
            if (vld && pipe_in_rdy) begin
                exp_q.push_back(pipe_in_pd);
                sent++;
                occ++;
            end
            stalled_q = pipe_out_vld & ~rdy;
            pd_q      = pipe_out_pd;
        end
        check("rand_done_beats", DW'(got), DW'(n_beats));
        check("rand_queue_empty", DW'(exp_q.size()), '0);
    endtask

    initial begin
        pipe_in_vld    = 1'b0;
        pipe_in_pd     = '0;
        pipe_out_rdy   = 1'b0;
        nvdla_core_rst = 1'b1;

        // Stall fill then drain from an empty slice; outputs are pre-edge state.
        vecs[0] = '{1'b1, mk(16'hAAAA, 16'h0001), 1'b0, 1'b1, 1'b0, '0};
        vecs[1] = '{1'b1, mk(16'hAAAA, 16'h0002), 1'b0, 1'b1, 1'b1, mk(16'hAAAA, 16'h0001)};
        vecs[2] = '{1'b1, mk(16'hAAAA, 16'h0003), 1'b0, 1'b0, 1'b1, mk(16'hAAAA, 16'h0001)};
        vecs[3] = '{1'b1, mk(16'hAAAA, 16'h0003), 1'b0, 1'b0, 1'b1, mk(16'hAAAA, 16'h0001)};
        vecs[4] = '{1'b1, mk(16'hAAAA, 16'h0003), 1'b1, 1'b0, 1'b1, mk(16'hAAAA, 16'h0001)};
        vecs[5] = '{1'b1, mk(16'hAAAA, 16'h0003), 1'b1, 1'b1, 1'b1, mk(16'hAAAA, 16'h0002)};
        vecs[6] = '{1'b0, '0,                     1'b1, 1'b1, 1'b1, mk(16'hAAAA, 16'h0003)};
        vecs[7] = '{1'b0, '0,                     1'b1, 1'b1, 1'b0, '0};

        repeat (3) @(negedge nvdla_core_clk);
        check("reset_in_rdy", DW'(pipe_in_rdy), DW'(1));
        check("reset_out_vld", DW'(pipe_out_vld), DW'(0));
        nvdla_core_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].in_vld, vecs[i].in_pd, vecs[i].out_rdy);
            check($sformatf("vec%0d_in_rdy", i), DW'(pipe_in_rdy), DW'(vecs[i].exp_in_rdy));
            check($sformatf("vec%0d_out_vld", i), DW'(pipe_out_vld), DW'(vecs[i].exp_out_vld));
            if (vecs[i].exp_out_vld) begin
                check($sformatf("vec%0d_out_pd", i), pipe_out_pd, vecs[i].exp_out_pd);
            end
        end

        // Streaming: back-to-back beats appear one cycle later with no bubbles.
        for (int i = 0; i <= 16; i++) begin
            drive(i < 16, DW'(i + 1), 1'b1);
            check("stream_in_rdy", DW'(pipe_in_rdy), DW'(1));
            check("stream_out_vld", DW'(pipe_out_vld), DW'(i >= 1));
            if (i >= 1) begin
                check("stream_out_pd", pipe_out_pd, DW'(i));
            end
        end
        drive(1'b0, '0, 1'b1);
        check("stream_idle_vld", DW'(pipe_out_vld), DW'(0));

        run_random(1000);

        // Mid-cycle reset with both entries full.
        drive(1'b1, 32'h5555_0001, 1'b0);
        drive(1'b1, 32'h5555_0002, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("prereset_in_rdy", DW'(pipe_in_rdy), DW'(0));
        check("prereset_out_vld", DW'(pipe_out_vld), DW'(1));
        #2 nvdla_core_rst = 1'b1;
        #1;
        check("async_rst_out_vld", DW'(pipe_out_vld), DW'(0));
        check("async_rst_in_rdy", DW'(pipe_in_rdy), DW'(1));
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            check("post_rst_out_vld", DW'(pipe_out_vld), DW'(0));
            check("post_rst_in_rdy", DW'(pipe_in_rdy), DW'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fp_sum_block_pipe_skid
